jk_bank_sequencer: RTL and testbench

- Command-driven controller for a bank of WIDTH external jk_flip_flop instances that share one clock.
- Accepts CLEAR/SET/LOAD/TOGGLE/COUNT commands over a valid/ready handshake and drives the bank's j/k inputs.
- Reads back q and checks that each step produced the expected value.
- Sits between a host/sequencing FSM and the flop bank; the bank is the only state the block manipulates.

---
 rtl/jk_bank_sequencer.sv | 151 +++++++++++++++
 tb/tb_jk_bank_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sequencer.sv
// Command sequencer for a bank of external JK flops: decodes CLEAR/SET/LOAD/TOGGLE/COUNT,
// drives j/k for one cycle per step and checks the q readback. Optional macro: JK_BANK_QNOT_CHECK_EN.
module jk_bank_sequencer #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STEP_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
    output logic [WIDTH-1:0]  j_out,
    output logic [WIDTH-1:0]  k_out,
    input  logic [WIDTH-1:0]  q_in,
`ifdef JK_BANK_QNOT_CHECK_EN
    input  logic [WIDTH-1:0]  q_not_in,
`endif
    output logic              done,
    output logic              mismatch,
    output logic              illegal,
    output logic [WIDTH-1:0]  result_q
);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_COUNT  = 3'd5;
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FIN} state_t;

    state_t              state;
    logic [WIDTH-1:0]    exp_q;
    logic [STEP_W-1:0]   remaining;
    logic                is_count;

    logic [WIDTH-1:0]    q_plus_c;
    logic                check_bad_c;

    // Next count value and the readback check against the expected bank value
    assign q_plus_c = WIDTH'(q_in + WIDTH'(1));
`ifdef JK_BANK_QNOT_CHECK_EN
    assign check_bad_c = (q_in != exp_q) || (q_not_in != ~q_in);
`else
    assign check_bad_c = (q_in != exp_q);
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            j_out     <= '0;
            k_out     <= '0;
            done      <= 1'b0;
            mismatch  <= 1'b0;
            illegal   <= 1'b0;
            result_q  <= '0;
            exp_q     <= '0;
            remaining <= '0;
            is_count  <= 1'b0;
        end else begin
            // j/k only carry a value for the single DRIVE cycle of each step
            done  <= 1'b0;
            j_out <= '0;
            k_out <= '0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        mismatch  <= 1'b0;
                        illegal   <= 1'b0;
                        cmd_ready <= 1'b0;
                        is_count  <= 1'b0;
                        state     <= DRIVE;
                        case (cmd_op)
                            OP_CLEAR: begin
                                k_out <= ONES;
                                exp_q <= '0;
                            end
                            OP_SET: begin
                                j_out <= ONES;
                                exp_q <= ONES;
                            end
                            OP_LOAD: begin
                                j_out <= cmd_data;
                                k_out <= ~cmd_data;
                                exp_q <= cmd_data;
                            end
                            OP_TOGGLE: begin
                                j_out <= cmd_data;
                                k_out <= cmd_data;
                                exp_q <= q_in ^ cmd_data;
                            end
                            OP_COUNT: begin
                                if (cmd_steps == '0) begin
                                    state <= FIN;
                                    done  <= 1'b1;
                                end else begin
                                    j_out     <= q_in ^ q_plus_c;
                                    k_out     <= q_in ^ q_plus_c;
                                    exp_q     <= q_plus_c;
                                    remaining <= cmd_steps - STEP_W'(1);
                                    is_count  <= 1'b1;
                                end
                            end
                            OP_NOP: begin
                                state <= FIN;
                                done  <= 1'b1;
                            end
                            default: begin
                                state   <= FIN;
                                done    <= 1'b1;
                                illegal <= 1'b1;
                            end
                        endcase
                    end
                end
                DRIVE: state <= CHECK;
                CHECK: begin
                    result_q <= q_in;
                    if (check_bad_c) begin
                        mismatch <= 1'b1;
                        state    <= FIN;
                        done     <= 1'b1;
                    end else if (is_count && (remaining != '0)) begin
                        j_out     <= q_in ^ q_plus_c;
                        k_out     <= q_in ^ q_plus_c;
                        exp_q     <= q_plus_c;
                        remaining <= remaining - STEP_W'(1);
                        state     <= DRIVE;
                    end else begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: behavioural JK bank plus an op-level reference model,
// directed and randomised commands with readback fault injection.
module tb_jk_bank_sequencer;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned STEP_W = 8;
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = 3'd0;
    logic [WIDTH-1:0]  cmd_data = '0;
    logic [STEP_W-1:0] cmd_steps = '0;
    logic [WIDTH-1:0]  j_out, k_out, q_in, result_q;
    logic              done, mismatch, illegal;

    logic [WIDTH-1:0]  bank_q = 4'b1011;
    logic              force_en = 1'b0;
    logic [WIDTH-1:0]  force_val = '0;

    assign q_in = force_en ? force_val : bank_q;

`ifdef JK_BANK_QNOT_CHECK_EN
    logic [WIDTH-1:0]  qnot_err = '0;
    logic [WIDTH-1:0]  q_not_in;
    bit                fault_qnot = 1'b0;
    assign q_not_in = ~bank_q ^ qnot_err;
`endif

    jk_bank_sequencer #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_steps (cmd_steps),
        .j_out     (j_out),
        .k_out     (k_out),
        .q_in      (q_in),
`ifdef JK_BANK_QNOT_CHECK_EN
        .q_not_in  (q_not_in),
`endif
        .done      (done),
        .mismatch  (mismatch),
        .illegal   (illegal),
        .result_q  (result_q)
    );

    always #5 clock = ~clock;

    // External JK flop bank
    always @(posedge clock) bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] m_q   = '0;
    logic [WIDTH-1:0] m_res = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Bank value after step i of an op, from the op's definition
    function automatic logic [WIDTH-1:0] target(input logic [2:0] op, input logic [WIDTH-1:0] data,
                                                input logic [WIDTH-1:0] q0, input int i);
        case (op)
            3'd1:    return '0;
            3'd2:    return ONES;
            3'd3:    return data;
            3'd4:    return q0 ^ data;
            default: return WIDTH'(q0 + WIDTH'(i));
        endcase
    endfunction

    task automatic run_cmd(input logic [2:0] op, input logic [WIDTH-1:0] data, input int steps,
                           input int fault_step, input logic [WIDTH-1:0] fault_mask, input string tag);
        int nsteps, lat, step;
        bit abort;
        logic [WIDTH-1:0] q0, qs, jexp, kexp, f_q, f_res;
        logic f_mis, f_ill;
        bit use_qnot;
        use_qnot = 1'b0;
`ifdef JK_BANK_QNOT_CHECK_EN
        use_qnot = fault_qnot;
`endif
        @(negedge clock);
        check($sformatf("%s ready_before", tag), 32'(cmd_ready), 32'd1);
        q0 = m_q;
        if (op >= 3'd1 && op <= 3'd4) nsteps = 1;
        else if (op == 3'd5) nsteps = steps;
        else nsteps = 0;
        abort = (fault_step > 0) && (fault_step <= nsteps);
        lat   = abort ? 2 * fault_step + 1 : 2 * nsteps + 1;
        f_ill = (op >= 3'd6);
        f_q   = m_q;
        f_res = m_res;
        f_mis = 1'b0;
        if (abort) begin
            f_q   = target(op, data, q0, fault_step);
            f_res = use_qnot ? f_q : f_q ^ fault_mask;
            f_mis = 1'b1;
        end else if (nsteps > 0) begin
            f_q   = target(op, data, q0, nsteps);
            f_res = f_q;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_steps = STEP_W'(steps);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = WIDTH'($urandom);
        cmd_steps = STEP_W'($urandom);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clock);
            force_en = 1'b0;
`ifdef JK_BANK_QNOT_CHECK_EN
            qnot_err = '0;
`endif
            if (abort && k == 2 * fault_step) begin
                if (use_qnot) begin
`ifdef JK_BANK_QNOT_CHECK_EN
                    qnot_err = fault_mask;
`endif
                end else begin
                    force_val = target(op, data, q0, fault_step) ^ fault_mask;
                    force_en  = 1'b1;
                end
            end
            step = (k + 1) / 2;
            jexp = '0;
            kexp = '0;
            if (k < lat && (k % 2) == 1) begin
                qs = (op == 3'd5) ? WIDTH'(q0 + WIDTH'(step - 1)) : q0;
                case (op)
                    3'd1: kexp = ONES;
                    3'd2: jexp = ONES;
                    3'd3: begin jexp = data; kexp = ~data; end
                    3'd4: begin jexp = data; kexp = data; end
                    default: begin jexp = qs ^ WIDTH'(qs + WIDTH'(1)); kexp = jexp; end
                endcase
            end
            if (k <= lat) begin
                check($sformatf("%s j@%0d", tag, k), 32'(j_out), 32'(jexp));
                check($sformatf("%s k@%0d", tag, k), 32'(k_out), 32'(kexp));
                check($sformatf("%s ready@%0d", tag, k), 32'(cmd_ready), 32'd0);
                check($sformatf("%s done@%0d", tag, k), 32'(done), 32'(k == lat));
                if (k == lat) begin
                    check($sformatf("%s mismatch", tag), 32'(mismatch), 32'(f_mis));
                    check($sformatf("%s illegal", tag), 32'(illegal), 32'(f_ill));
                    check($sformatf("%s result_q", tag), 32'(result_q), 32'(f_res));
                end
            end else begin
                check($sformatf("%s done_pulse_end", tag), 32'(done), 32'd0);
                check($sformatf("%s ready_after", tag), 32'(cmd_ready), 32'd1);
                check($sformatf("%s bank_q", tag), 32'(bank_q), 32'(f_q));
            end
        end
        m_q   = f_q;
        m_res = f_res;
    endtask

    initial begin
        int op, st, fs;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst j", 32'(j_out), 32'd0);
        check("rst k", 32'(k_out), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst mismatch", 32'(mismatch), 32'd0);
        check("rst illegal", 32'(illegal), 32'd0);
        check("rst result_q", 32'(result_q), 32'd0);
        check("rst ready", 32'(cmd_ready), 32'd1);
        reset_n = 1'b1;

        run_cmd(3'd1, 4'b0000, 0, 0, '0, "clear");
        run_cmd(3'd3, 4'b1010, 0, 0, '0, "load_a");
        run_cmd(3'd4, 4'b0110, 0, 0, '0, "toggle_6");
        run_cmd(3'd2, 4'b0000, 0, 0, '0, "set");
        run_cmd(3'd1, 4'b0000, 0, 0, '0, "clear2");
        run_cmd(3'd5, 4'b0000, 17, 0, '0, "count17");
        run_cmd(3'd3, 4'b0101, 0, 1, 4'b0001, "load_fault");
        run_cmd(3'd5, 4'b0000, 5, 2, 4'b0011, "count_fault");
        run_cmd(3'd7, 4'b1111, 3, 0, '0, "op7");
        run_cmd(3'd0, 4'b1111, 3, 0, '0, "nop");
        run_cmd(3'd5, 4'b1111, 0, 0, '0, "count0");
        run_cmd(3'd6, 4'b0011, 0, 0, '0, "op6");

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 7);
            st = $urandom_range(0, 6);
            fs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_cmd(3'(op), WIDTH'($urandom), st, fs, WIDTH'($urandom_range(1, 15)),
                    $sformatf("rand%0d", i));
        end

        // Reset during the first DRIVE of a COUNT
        run_cmd(3'd1, 4'b0000, 0, 0, '0, "clear_pre_rst");
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        cmd_steps = STEP_W'(10);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        @(negedge clock);
        check("midrst drive j", 32'(j_out), 32'd1);
        check("midrst drive k", 32'(k_out), 32'd1);
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst ready", 32'(cmd_ready), 32'd1);
        check("midrst j", 32'(j_out), 32'd0);
        check("midrst k", 32'(k_out), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst result_q", 32'(result_q), 32'd0);
        check("midrst bank_q", 32'(bank_q), 32'd1);
        reset_n = 1'b1;
        m_q   = 4'b0001;
        m_res = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check($sformatf("midrst no_done%0d", i), 32'(done), 32'd0);
        end
        run_cmd(3'd1, 4'b0000, 0, 0, '0, "clear_post_rst");

`ifdef JK_BANK_QNOT_CHECK_EN
        fault_qnot = 1'b1;
        run_cmd(3'd3, 4'b1001, 0, 1, 4'b0100, "qnot_fault");
        run_cmd(3'd5, 4'b0000, 4, 3, 4'b1000, "qnot_count_fault");
        fault_qnot = 1'b0;
        run_cmd(3'd2, 4'b0000, 0, 0, '0, "qnot_clean");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
